// File: rtl/cam_pkg.sv
// Shared types, default geometry and pixel conversion for the camera capture path.
// No logic and no storage. There is no flow control here.
package cam_pkg;

    typedef enum logic [1:0] {
        WAIT_VSYNC_HI,
        WAIT_VSYNC_LO,
        BYTE_HI,
        BYTE_LO
    } cam_state_e;

    localparam int DEF_IMG_WIDTH  = 320;
    localparam int DEF_IMG_HEIGHT = 240;
    localparam int DEF_ADDR_W     = 17;

    // The sensor sends RGB565 as {R5,G3hi} then {G3lo,B5}; keep the top bits of each field.
    function automatic logic [7:0] rgb565_to_332(input logic [7:0] b1, input logic [7:0] b2);
        return {b1[7:5], b1[2:0], b2[4:3]};
    endfunction

endpackage

// File: rtl/cam_capture_if.sv
// Camera pin bundle and frame-buffer write port.
// Wires only, so there is no latency. There is no backpressure: the sensor cannot be stalled.
interface cam_capture_if #(
    parameter int ADDR_W = 17
);
    logic              vsync;
    logic              href;
    logic [7:0]        input_data;
    logic [ADDR_W-1:0] mem_px_addr;
    logic [7:0]        mem_px_data;
    logic              px_wr;
    logic              frame_done;

    modport master (
        input  vsync, href, input_data,
        output mem_px_addr, mem_px_data, px_wr, frame_done
    );

    modport slave (
        output vsync, href, input_data,
        input  mem_px_addr, mem_px_data, px_wr, frame_done
    );
endinterface

// File: rtl/cam_xclk_gate.sv
// Gates the PLL clock out to the sensor. It is kept apart so a library clock-gate cell can replace it.
// The path is combinational, with zero latency. It has no flow control.
module cam_xclk_gate (
    input  logic clk_i,
    input  logic en_i,
    output logic gclk_o
);
    assign gclk_o = clk_i & en_i;
endmodule

// File: rtl/cam_capture.sv
// Tracks the camera framing, turns each pair of RGB565 bytes into one RGB332 frame-buffer write.
// The write strobe is registered and appears 1 pclk after the second byte. There is no backpressure; excess pixels are dropped.
module cam_capture
    import cam_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          clk_pll,
    input  logic          enable_xclk,
    output logic          xclk,
    cam_capture_if.master bus
);

    localparam int CW = $clog2(IMG_WIDTH + 1);
    localparam int RW = $clog2(IMG_HEIGHT + 1);
    localparam logic [CW-1:0]     COL_MAX = CW'(IMG_WIDTH);
    localparam logic [RW-1:0]     ROW_MAX = RW'(IMG_HEIGHT);
    localparam logic [ADDR_W-1:0] LINE_W  = ADDR_W'(IMG_WIDTH);

    cam_state_e        state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [7:0]        byte_q, byte_d;
    logic              vsync_q, href_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              wr_q, wr_d;
    logic              done_q, done_d;

    logic              vsync_rise, vsync_fall, href_fall;
    logic [ADDR_W-1:0] pix_addr;
    logic [CW-1:0]     col_inc;
    logic [RW-1:0]     row_inc;

    cam_xclk_gate u_xclk_gate (
        .clk_i  (clk_pll),
        .en_i   (enable_xclk),
        .gclk_o (xclk)
    );

    assign vsync_rise = !vsync_q && bus.vsync;
    assign vsync_fall = vsync_q && !bus.vsync;
    assign href_fall  = href_q && !bus.href;
    assign pix_addr   = ADDR_W'(row_q) * LINE_W + ADDR_W'(col_q);
    assign col_inc    = (col_q == COL_MAX) ? col_q : col_q + 1'b1;
    assign row_inc    = (row_q == ROW_MAX) ? row_q : row_q + 1'b1;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        byte_d  = byte_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            WAIT_VSYNC_HI: begin
                if (bus.vsync) begin
                    state_d = WAIT_VSYNC_LO;
                end
            end
            WAIT_VSYNC_LO: begin
                if (vsync_fall) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = BYTE_HI;
                end
            end
            BYTE_HI, BYTE_LO: begin
                if (vsync_rise) begin
                    done_d  = 1'b1;
                    state_d = WAIT_VSYNC_LO;
                end else if (!bus.vsync) begin
                    if (href_fall) begin
                        col_d   = '0;
                        row_d   = row_inc;
                        state_d = BYTE_HI;
                    end else if (bus.href) begin
                        if (state_q == BYTE_HI) begin
                            byte_d  = bus.input_data;
                            state_d = BYTE_LO;
                        end else begin
                            if (col_q < COL_MAX && row_q < ROW_MAX) begin
                                wr_d   = 1'b1;
                                data_d = rgb565_to_332(byte_q, bus.input_data);
                                addr_d = pix_addr;
                            end
                            col_d   = col_inc;
                            state_d = BYTE_HI;
                        end
                    end
                end
            end
            default: state_d = WAIT_VSYNC_HI;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            state_q <= WAIT_VSYNC_HI;
            col_q   <= '0;
            row_q   <= '0;
            byte_q  <= '0;
            vsync_q <= 1'b1;
            href_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            byte_q  <= byte_d;
            vsync_q <= bus.vsync;
            href_q  <= bus.href;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
        end
    end

    assign bus.mem_px_addr = addr_q;
    assign bus.mem_px_data = data_q;
    assign bus.px_wr       = wr_q;
    assign bus.frame_done  = done_q;

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture on a reduced 8x4 image.
module tb_cam_capture;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int AW = 5;

    logic pclk        = 1'b0;
    logic rst         = 1'b0;
    logic clk_pll     = 1'b0;
    logic enable_xclk = 1'b0;
    logic xclk;

    cam_capture_if #(.ADDR_W(AW)) bus ();

    cam_capture #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .ADDR_W     (AW)
    ) dut (
        .pclk        (pclk),
        .rst         (rst),
        .clk_pll     (clk_pll),
        .enable_xclk (enable_xclk),
        .xclk        (xclk),
        .bus         (bus)
    );

    always #5 pclk = ~pclk;
    always #3 clk_pll = ~clk_pll;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    logic [AW-1:0] wa[$];
    logic [7:0]    wd[$];

    always @(negedge pclk) begin
        if (bus.px_wr === 1'b1) begin
            wa.push_back(bus.mem_px_addr);
            wd.push_back(bus.mem_px_data);
        end
        if (bus.frame_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_line(input int n, input logic [7:0] b1, input logic [7:0] b2);
        for (int i = 0; i < n; i++) begin
            @(negedge pclk);
            bus.href = 1'b1;
            bus.input_data = (i % 2 == 0) ? b1 : b2;
        end
        @(negedge pclk);
        bus.href = 1'b0;
        repeat (2) @(negedge pclk);
    endtask

    task automatic frame_start();
        @(negedge pclk);
        bus.vsync = 1'b1;
        repeat (2) @(negedge pclk);
        bus.vsync = 1'b0;
        repeat (2) @(negedge pclk);
    endtask

    task automatic frame_end();
        int d0;
        d0 = done_cnt;
        @(negedge pclk);
        bus.vsync = 1'b1;
        @(negedge pclk);
        chk("frame_done_pulse", 32'(bus.frame_done), 32'd1);
        @(negedge pclk);
        chk("frame_done_drop", 32'(bus.frame_done), 32'd0);
        repeat (3) @(negedge pclk);
        chk("frame_done_count", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [7:0] odd_seq[3];

        bus.vsync = 1'b0;
        bus.href = 1'b0;
        bus.input_data = 8'h00;

        // Reset held with framing inputs toggling
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            chk("rst_px_wr", 32'(bus.px_wr), 32'd0);
            chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
            chk("rst_addr", 32'(bus.mem_px_addr), 32'd0);
            bus.href = (i % 2 == 1);
            bus.vsync = (i % 2 == 0);
            bus.input_data = 8'h5A;
        end
        @(negedge pclk);
        bus.vsync = 1'b0;
        bus.href = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge pclk);
        drive_line(4, 8'hCD, 8'hAB);
        chk("no_wr_before_vsync", 32'(wa.size()), 32'd0);

        // xclk gating
        enable_xclk = 1'b1;
        repeat (3) begin
            @(posedge clk_pll); #1;
            chk("xclk_on_hi", 32'(xclk), 32'd1);
            @(negedge clk_pll); #1;
            chk("xclk_on_lo", 32'(xclk), 32'd0);
        end
        enable_xclk = 1'b0;
        repeat (3) begin
            @(posedge clk_pll); #1;
            chk("xclk_off", 32'(xclk), 32'd0);
        end
        enable_xclk = 1'b1;
        @(posedge clk_pll); #1;
        chk("xclk_reen", 32'(xclk), 32'd1);

        // Pixel conversion and write timing
        frame_start();
        @(negedge pclk); bus.href = 1'b1; bus.input_data = 8'hCD;
        @(negedge pclk);
        chk("p0_wr_early", 32'(bus.px_wr), 32'd0);
        bus.input_data = 8'hAB;
        @(negedge pclk);
        chk("p0_wr", 32'(bus.px_wr), 32'd1);
        chk("p0_addr", 32'(bus.mem_px_addr), 32'd0);
        chk("p0_data", 32'(bus.mem_px_data), 32'hD5);
        bus.input_data = 8'hEF;
        @(negedge pclk);
        chk("p0_wr_one_cycle", 32'(bus.px_wr), 32'd0);
        bus.input_data = 8'h10;
        @(negedge pclk);
        chk("p1_wr", 32'(bus.px_wr), 32'd1);
        chk("p1_addr", 32'(bus.mem_px_addr), 32'd1);
        chk("p1_data", 32'(bus.mem_px_data), 32'hFE);
        bus.href = 1'b0;
        @(negedge pclk);
        chk("p1_wr_one_cycle", 32'(bus.px_wr), 32'd0);
        chk("hold_addr", 32'(bus.mem_px_addr), 32'd1);
        chk("hold_data", 32'(bus.mem_px_data), 32'hFE);
        @(negedge pclk);

        // Odd trailing byte dropped, next line restarts on the high byte
        base = wa.size();
        odd_seq = '{8'hCD, 8'hAB, 8'h00};
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            bus.href = 1'b1;
            bus.input_data = odd_seq[i];
        end
        @(negedge pclk);
        bus.href = 1'b0;
        repeat (2) @(negedge pclk);
        drive_line(2, 8'hCD, 8'hAB);
        chk("odd_wr_count", 32'(wa.size() - base), 32'd2);
        if (wa.size() - base == 2) begin
            chk("odd_addr0", 32'(wa[base]), 32'd8);
            chk("odd_data0", 32'(wd[base]), 32'hD5);
            chk("odd_addr1", 32'(wa[base+1]), 32'd16);
            chk("odd_data1", 32'(wd[base+1]), 32'hD5);
        end
        frame_end();

        // Full frame: wide lines are clipped at W pixels
        base = wa.size();
        frame_start();
        for (int r = 0; r < H; r++) drive_line(2*W + 6, 8'hCD, 8'hAB);
        chk("frame_wr_count", 32'(wa.size() - base), 32'(W*H));
        if (wa.size() - base == W*H) begin
            for (int i = 0; i < W*H; i++) begin
                chk("frame_addr", 32'(wa[base+i]), 32'(i));
                chk("frame_data", 32'(wd[base+i]), 32'hD5);
            end
        end
        frame_end();

        // Extra lines beyond H produce no writes
        base = wa.size();
        frame_start();
        for (int r = 0; r < H + 2; r++) drive_line(2*W, 8'hFF, 8'h00);
        chk("extra_wr_count", 32'(wa.size() - base), 32'(W*H));
        if (wa.size() - base == W*H) begin
            for (int i = 0; i < W*H; i++) begin
                chk("extra_addr", 32'(wa[base+i]), 32'(i));
                chk("extra_data", 32'(wd[base+i]), 32'hFC);
            end
        end
        frame_end();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
